// File: rtl/hardware_heap_arbiter_pkg.sv
// Shared definitions for the heap arbiter: default widths and requester identity.
package hardware_heap_arbiter_pkg;

  localparam int WORD_W_DEF = 130;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic {
    REQ_REDUCER   = 1'b0,
    REQ_COLLECTOR = 1'b1
  } req_id_e;

endpackage

// File: rtl/hardware_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational; the pointer remembers
// the most recently granted requester and only moves when advance is high.
module hardware_rr_arb2
  import hardware_heap_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_e last_q;

  // Single requester wins outright; under contention the one not granted last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_q == REQ_COLLECTOR) ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts as "collector granted last" so the reducer wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_COLLECTOR;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1] ? REQ_COLLECTOR : REQ_REDUCER;
    end
  end

endmodule

// File: rtl/hardware_heap_arbiter.sv
// Arbitrates a reducer and a collector onto one single-port heap RAM and
// returns read data to the issuing requester two cycles after the handshake.
module hardware_heap_arbiter
  import hardware_heap_arbiter_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WORD_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WORD_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [WORD_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [WORD_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       rd_hs;
  req_id_e    rd_id;

  // Requests are masked while reset is asserted so ready and mem_* stay low.
  assign req_vec = {req1_valid, req0_valid} & {2{system1000_rstn}};

  hardware_rr_arb2 u_arb (
    .clk     (system1000),
    .rst_n   (system1000_rstn),
    .req     (req_vec),
    .advance (|grant),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Steer the granted requester's fields onto the RAM port in the same cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[0]) begin
      mem_en    = 1'b1;
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (grant[1]) begin
      mem_en    = 1'b1;
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  assign rd_hs = (grant[0] && !req0_we) || (grant[1] && !req1_we);
  assign rd_id = grant[1] ? REQ_COLLECTOR : REQ_REDUCER;

  // ---- stage p0: tag of the read issued this cycle, aligned with mem_rdata ----
  logic    tag_vld_p0;
  req_id_e tag_id_p0;

  // Record which requester owns the RAM read now in flight.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      tag_vld_p0 <= 1'b0;
      tag_id_p0  <= REQ_REDUCER;
    end else begin
      tag_vld_p0 <= rd_hs;
      tag_id_p0  <= rd_id;
    end
  end

  // ---- stage p1: capture RAM data into the owner's response register ----
  logic              rsp0_vld_p1;
  logic              rsp1_vld_p1;
  logic [WORD_W-1:0] rsp0_rdata_p1;
  logic [WORD_W-1:0] rsp1_rdata_p1;

  // Route the returning word to its owner and raise a one-cycle valid pulse.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      rsp0_vld_p1   <= 1'b0;
      rsp1_vld_p1   <= 1'b0;
      rsp0_rdata_p1 <= '0;
      rsp1_rdata_p1 <= '0;
    end else begin
      rsp0_vld_p1 <= tag_vld_p0 && (tag_id_p0 == REQ_REDUCER);
      rsp1_vld_p1 <= tag_vld_p0 && (tag_id_p0 == REQ_COLLECTOR);
      if (tag_vld_p0 && (tag_id_p0 == REQ_REDUCER)) begin
        rsp0_rdata_p1 <= mem_rdata;
      end
      if (tag_vld_p0 && (tag_id_p0 == REQ_COLLECTOR)) begin
        rsp1_rdata_p1 <= mem_rdata;
      end
    end
  end

  assign rsp0_valid = rsp0_vld_p1;
  assign rsp1_valid = rsp1_vld_p1;
  assign rsp0_rdata = rsp0_rdata_p1;
  assign rsp1_rdata = rsp1_rdata_p1;

endmodule

// File: tb/tb_hardware_heap_arbiter.sv
// Bench for hardware_heap_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a transaction-level model.
module tb_hardware_heap_arbiter;

  localparam int W = 130;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         r0_valid, r0_we, r1_valid, r1_we;
  logic [A-1:0] r0_addr, r1_addr;
  logic [W-1:0] r0_wdata, r1_wdata;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_rdata, rsp1_rdata;
  logic         mem_en, mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  hardware_heap_arbiter #(.WORD_W(W), .ADDR_W(A)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .req0_valid      (r0_valid),
    .req0_we         (r0_we),
    .req0_addr       (r0_addr),
    .req0_wdata      (r0_wdata),
    .req0_ready      (req0_ready),
    .req1_valid      (r1_valid),
    .req1_we         (r1_we),
    .req1_addr       (r1_addr),
    .req1_wdata      (r1_wdata),
    .req1_ready      (req1_ready),
    .rsp0_valid      (rsp0_valid),
    .rsp0_rdata      (rsp0_rdata),
    .rsp1_valid      (rsp1_valid),
    .rsp1_rdata      (rsp1_rdata),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_word(input int a);
    logic [15:0] a16;
    a16 = a[15:0] ^ 16'hA5C3;
    return {2'b11, {8{a16}}};
  endfunction

  // Heap RAM environment: registered read data, one cycle after enable.
  logic [W-1:0] ram_env [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram_env[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram_env.exists(int'(mem_addr)) ? ram_env[int'(mem_addr)]
                                                        : init_word(int'(mem_addr));
    end
  end

  // Reference model state: heap contents, last granted id, expected responses.
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;

  logic [W-1:0] model_mem [int];
  exp_t         q[$];
  int           last_id = 1;
  int           cyc = 0;
  int           wait0 = 0;
  int           wait1 = 0;

  function automatic logic [W-1:0] rd_model(input int a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model.
  task automatic model_cycle();
    int           g;
    exp_t         e;
    logic         ex0, ex1, ewe;
    logic [W-1:0] ed;
    cyc++;
    g = -1;
    if (rstn) begin
      if (r0_valid && r1_valid) g = (last_id == 1) ? 0 : 1;
      else if (r0_valid) g = 0;
      else if (r1_valid) g = 1;
    end
    ex0 = 1'b0; ex1 = 1'b0; ed = '0;
    if (rstn && q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ed = e.data;
      if (e.id == 0) ex0 = 1'b1; else ex1 = 1'b1;
    end
    ewe = (g == 0) ? r0_we : (g == 1) ? r1_we : 1'b0;
    check_bit("ready0", req0_ready, g == 0);
    check_bit("ready1", req1_ready, g == 1);
    check_bit("one_ready", req0_ready && req1_ready, 1'b0);
    check_bit("mem_en", mem_en, g >= 0);
    check_bit("mem_we", mem_we, ewe);
    if (g >= 0) begin
      check_word("mem_addr", W'(mem_addr), W'((g == 0) ? r0_addr : r1_addr));
      if (ewe) check_word("mem_wdata", mem_wdata, (g == 0) ? r0_wdata : r1_wdata);
    end
    check_bit("rsp0_valid", rsp0_valid, ex0);
    check_bit("rsp1_valid", rsp1_valid, ex1);
    if (ex0) check_word("rsp0_rdata", rsp0_rdata, ed);
    if (ex1) check_word("rsp1_rdata", rsp1_rdata, ed);
    wait0 = (rstn && r0_valid && !req0_ready) ? wait0 + 1 : 0;
    wait1 = (rstn && r1_valid && !req1_ready) ? wait1 + 1 : 0;
    if (rstn && r0_valid) check_bit("starve0", wait0 > 1, 1'b0);
    if (rstn && r1_valid) check_bit("starve1", wait1 > 1, 1'b0);
    if (!rstn) begin
      last_id = 1;
      q.delete();
    end else if (g >= 0) begin
      last_id = g;
      if (ewe) begin
        model_mem[int'((g == 0) ? r0_addr : r1_addr)] = (g == 0) ? r0_wdata : r1_wdata;
      end else begin
        e.due  = cyc + 2;
        e.id   = g;
        e.data = rd_model(int'((g == 0) ? r0_addr : r1_addr));
        q.push_back(e);
      end
    end
  endtask

  task automatic set_in(input logic v0, input logic we0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                        input logic v1, input logic we1, input logic [A-1:0] a1, input logic [W-1:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit           exp_g0 [4];
    int           pulses;
    logic [159:0] rnd;
    logic [W-1:0] d0, d1;
    exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};
    ram_env[16]   = W'(130'h2A);
    model_mem[16] = W'(130'h2A);
    mem_rdata = '0;
    rstn = 1'b0;
    // Requests presented during reset must not be accepted.
    set_in(1'b1, 1'b0, 16'h0010, '0, 1'b1, 1'b1, 16'h0003, W'(130'h5));
    for (int i = 0; i < 3; i++) begin
      sample();
      check_word("rst_rdata0", rsp0_rdata, '0);
      check_word("rst_rdata1", rsp1_rdata, '0);
      check_bit("rst_mem_en", mem_en, 1'b0);
      advance();
    end
    rstn = 1'b1;

    // Single reducer read of 0x0010 holding 0x2A.
    set_in(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    sample();
    check_bit("first_ready0", req0_ready, 1'b1);
    check_word("first_addr", W'(mem_addr), W'(130'h10));
    advance();
    idle_in();
    sample();
    advance();
    sample();
    check_bit("first_rsp0", rsp0_valid, 1'b1);
    check_word("first_rdata", rsp0_rdata, W'(130'h2A));
    check_bit("first_rsp1", rsp1_valid, 1'b0);
    advance();

    // Collector read so that the reducer wins the next contention.
    set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0003, '0);
    sample();
    advance();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b0, 16'h0002, '0);
      sample();
      check_bit("alt_grant0", req0_ready, exp_g0[i]);
      check_bit("alt_grant1", req1_ready, !exp_g0[i]);
      advance();
    end
    idle_in();
    repeat (2) begin sample(); advance(); end

    // Collector write then reducer read of the same address.
    set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0005, W'(130'h3FF));
    sample();
    check_bit("wr_mem_we", mem_we, 1'b1);
    check_word("wr_mem_wdata", mem_wdata, W'(130'h3FF));
    advance();
    set_in(1'b1, 1'b0, 16'h0005, '0, 1'b0, 1'b0, '0, '0);
    sample();
    check_bit("rd_mem_we", mem_we, 1'b0);
    advance();
    idle_in();
    sample();
    check_bit("no_wr_rsp", rsp1_valid, 1'b0);
    advance();
    sample();
    check_bit("raw_rsp0", rsp0_valid, 1'b1);
    check_word("raw_rdata", rsp0_rdata, W'(130'h3FF));
    advance();

    // Read then reset pulse: response discarded, reducer wins next contention.
    set_in(1'b1, 1'b0, 16'h0007, '0, 1'b0, 1'b0, '0, '0);
    sample();
    advance();
    idle_in();
    rstn = 1'b0;
    sample();
    advance();
    rstn = 1'b1;
    set_in(1'b1, 1'b0, 16'h0008, '0, 1'b1, 1'b0, 16'h0009, '0);
    sample();
    check_bit("post_rst_rsp0", rsp0_valid, 1'b0);
    check_bit("post_rst_g0", req0_ready, 1'b1);
    check_bit("post_rst_g1", req1_ready, 1'b0);
    advance();
    idle_in();
    repeat (2) begin sample(); advance(); end

    // Collector alone streams eight reads.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0020 + 16'(i), '0);
      else idle_in();
      sample();
      if (i < 8) begin
        check_bit("stream_ready1", req1_ready, 1'b1);
        check_bit("stream_ready0", req0_ready, 1'b0);
      end
      if (rsp1_valid) pulses++;
      advance();
    end
    check_word("stream_pulses", W'(pulses), W'(130'd8));

    // Randomized traffic with address collisions.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      d0 = rnd[W-1:0];
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      d1 = rnd[W-1:0];
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 16'($urandom_range(0, 63)), d0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 16'($urandom_range(0, 63)), d1);
      sample();
      advance();
    end
    idle_in();
    repeat (3) begin sample(); advance(); end
    check_word("drained", W'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hardware_heap_arbiter.md
HARDWARE_HEAP_ARBITER -- requirements
Module: hardware_heap_arbiter

Interface
REQ-001 Parameter WORD_W, default 130, heap word width (matches the reduction-machine node word).
REQ-002 Parameter ADDR_W, default 16, heap word address width.
REQ-003 system1000  in  1  clock; all state updates on rising edge.
REQ-004 system1000_rstn  in  1  reset, asynchronous, active-low.
REQ-005 reqN_valid  in  1  requester N (N=0 reducer, N=1 collector) presents an access.
REQ-006 reqN_we  in  1  1=write, 0=read; qualified by reqN_valid.
REQ-007 reqN_addr  in  ADDR_W  heap address.
REQ-008 reqN_wdata  in  WORD_W  write data.
REQ-009 reqN_ready  out  1  access accepted this cycle (valid&&ready = handshake).
REQ-010 rspN_valid  out  1  read data for requester N valid, one-cycle pulse.
REQ-011 rspN_rdata  out  WORD_W  read data; don't-care when rspN_valid=0.
REQ-012 mem_en  out  1  single-port heap RAM enable.
REQ-013 mem_we  out  1  heap RAM write enable.
REQ-014 mem_addr  out  ADDR_W  heap RAM address.
REQ-015 mem_wdata  out  WORD_W  heap RAM write data.
REQ-016 mem_rdata  in  WORD_W  heap RAM read data, valid exactly 1 cycle after mem_en&&!mem_we.

Function
REQ-017 At most one requester SHALL be granted per cycle; grant is combinational from current reqN_valid and priority pointer.
REQ-018 Single requester valid -> that requester granted same cycle (reqN_ready=1), zero added latency.
REQ-019 Both valid -> requester not granted most recently wins; priority pointer updates only on a completed handshake.
REQ-020 reqN_ready SHALL be 0 when reqN_valid=0; at most one ready high per cycle.
REQ-021 On handshake: mem_en=1, mem_we=reqN_we, mem_addr/mem_wdata = granted requester's fields, same cycle; otherwise mem_en=0, mem_we=0.
REQ-022 Read handshake SHALL register pending tag {valid=1, id=N}; next cycle capture mem_rdata into rspN_rdata register, and the cycle after assert rspN_valid (total read latency 2 cycles from handshake).
REQ-023 Reads SHALL be fully pipelined: one handshake per cycle, responses returned in issue order, no bubbles.
REQ-024 Writes SHALL produce no response.
REQ-025 Responses have no backpressure; requesters SHALL always accept rspN_valid.
REQ-026 Read and write to same address in consecutive cycles: RAM ordering preserved; arbiter adds no forwarding.
REQ-027 Continuous dual contention SHALL alternate grants 0,1,0,1...; neither requester waits more than 1 cycle.
REQ-028 Requester dropping valid without handshake is legal; no state changes.

Reset
REQ-029 Reset asserted: rsp0_valid=rsp1_valid=0, pending tags cleared, priority pointer = requester 1 most recent (requester 0 wins first contention), rdata registers zero.
REQ-030 Outputs reqN_ready and mem_* are combinational and SHALL be 0 while reset asserted.
REQ-031 Reset mid-read SHALL discard in-flight reads; no rspN_valid after reset release for pre-reset requests.

Structure
REQ-032 Shared package holds WORD_W, ADDR_W defaults and requester-id type (1 bit, REQ_REDUCER=0, REQ_COLLECTOR=1).
REQ-033 Two-way round-robin arbitration SHALL be a sub-module hardware_rr_arb2 (inputs req[1:0], advance; output one-hot grant; pointer register inside).
REQ-034 Read pipeline (tag stage, data stage) SHALL live in the top module.

Verification
REQ-035 Reset release, req0 read addr 0x0010 (RAM holds 0x2A) -> ready0 same cycle, mem_en=1 addr 0x0010, rsp0_valid 2 cycles later with rdata 0x2A, rsp1_valid never.
REQ-036 Both valid reads for 4 cycles, addrs 0x1/0x2 -> grants 0,1,0,1; rsp0/rsp1 alternate with correct data, one per cycle.
REQ-037 req1 write addr 0x0005 data 0x3FF then req0 read 0x0005 next cycle -> mem_we 1 then 0, rsp0_rdata=0x3FF, no write response.
REQ-038 req0 read handshake then reset pulse next cycle -> no rsp0_valid after release; next contention grants requester 0.
REQ-039 req1 sole valid for 8 cycles with reads -> ready1 every cycle, 8 rsp1_valid pulses in order, ready0 stays 0.
REQ-040 Random valid/we/addr on both ports 10k cycles vs reference model -> at most one ready per cycle, no starvation beyond 1 cycle, all read data matches.
